// File: rtl/cic_comb_decimator.sv
// First-order CIC comb stage: decimates the integrator stream by DECIM_FACTOR and emits
// data_i - data_i(previous window). Define CIC_COMB_OVF_FLAG_EN to add the sticky ovf_o flag.
module cic_comb_decimator #(
  parameter int unsigned BW           = 8,
  parameter int unsigned DECIM_FACTOR = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic [BW-1:0] data_i,
  input  logic          valid_i,
  output logic [BW-1:0] data_o,
  output logic          valid_o
`ifdef CIC_COMB_OVF_FLAG_EN
  ,
  output logic          ovf_o
`endif
);

  localparam int unsigned CntW = (DECIM_FACTOR > 2) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DECIM_FACTOR - 1);

  typedef enum logic {StPrime, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BW-1:0]   dly_q, dly_d;
  logic [BW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   diff;

  // Modular subtraction undoes integrator wrap-around.
  assign diff = data_i - dly_q;

`ifdef CIC_COMB_OVF_FLAG_EN
  logic          ovf_q, ovf_d;
  logic [BW-1:0] diff_mag;
  logic          diff_big;

  // Magnitude as unsigned BW bits; -2^(BW-1) maps to 2^(BW-1) correctly.
  assign diff_mag = diff[BW-1] ? (~diff + BW'(1)) : diff;
  assign diff_big = {1'b0, diff_mag} > (BW+1)'(DECIM_FACTOR);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef CIC_COMB_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    if (!en_i) begin
      state_d = StPrime;
      cnt_d   = '0;
      dly_d   = '0;
`ifdef CIC_COMB_OVF_FLAG_EN
      ovf_d   = 1'b0;
`endif
    end else if (valid_i) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        dly_d = data_i;
        unique case (state_q)
          StPrime: state_d = StRun;
          StRun: begin
            data_d  = diff;
            valid_d = 1'b1;
`ifdef CIC_COMB_OVF_FLAG_EN
            if (diff_big) ovf_d = 1'b1;
`endif
          end
          default: state_d = StPrime;
        endcase
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StPrime;
      cnt_q   <= '0;
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef CIC_COMB_OVF_FLAG_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Self-checking bench for cic_comb_decimator (BW=8, DECIM_FACTOR=4) against a queue-based model.
module tb_cic_comb_decimator;

  localparam int unsigned BW = 8;
  localparam int unsigned R  = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          en_i = 1'b0;
  logic [BW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic [BW-1:0] data_o;
  logic          valid_o;
`ifdef CIC_COMB_OVF_FLAG_EN
  logic          ovf_o;
`endif

  cic_comb_decimator #(
    .BW           (BW),
    .DECIM_FACTOR (R)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .data_o  (data_o),
`ifdef CIC_COMB_OVF_FLAG_EN
    .ovf_o   (ovf_o),
`endif
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int failures  = 0;

  // Model: every accepted sample since the last clear; an output appears on each
  // R-th sample from the 2R-th on, equal to the sample minus the one R earlier.
  logic [BW-1:0] hist[$];
  logic [BW-1:0] exp_data  = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ovf   = 1'b0;

  task automatic model_clear(input bit full_reset);
    hist.delete();
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    if (full_reset) exp_data = '0;
  endtask

  // Drive one cycle; outputs are settled 1 time unit after the edge.
  task automatic step(input bit en, input bit vld, input logic [BW-1:0] d);
    int k;
    int sd;
    en_i = en; valid_i = vld; data_i = d;
    @(posedge clk_i);
    #1;
    exp_valid = 1'b0;
    if (!en) begin
      model_clear(1'b0);
    end else if (vld) begin
      hist.push_back(d);
      k = hist.size();
      if (k % R == 0 && k >= 2 * R) begin
        exp_valid = 1'b1;
        exp_data  = hist[k-1] - hist[k-1-R];
        sd = int'($signed(exp_data));
        if (sd > int'(R) || sd < -int'(R)) exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #7;
    model_clear(1'b1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic check_outputs(input string name);
    tests_run++;
    if (valid_o !== exp_valid || (exp_valid && data_o !== exp_data)) begin
      failures++;
      $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h",
               name, valid_o, data_o, exp_valid, exp_data);
    end
  endtask

  task automatic test_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, BW'(i));
    // Async reset mid-cycle with data_o holding 4.
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (data_o !== '0 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got data=%h valid=%b, expected data=00 valid=0", data_o, valid_o);
    end
    model_clear(1'b1);
    #3;
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'h5a);
      tests_run++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_prime: got valid=%b, expected 0 at sample %0d", valid_o, i + 1);
      end
    end
  endtask

  task automatic test_steady();
    step(1'b0, 1'b0, '0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1, BW'(i));
      tests_run++;
      if (valid_o !== ((i == 8 || i == 12) ? 1'b1 : 1'b0) ||
          ((i == 8 || i == 12) && data_o !== 8'd4)) begin
        failures++;
        $display("FAIL steady_s%0d: got valid=%b data=%h, expected valid=%b data=04",
                 i, valid_o, data_o, (i == 8 || i == 12));
      end
    end
  endtask

  task automatic test_wrap();
    logic [BW-1:0] primes[2] = '{8'd254, 8'd3};
    logic [BW-1:0] finals[2] = '{8'd2, 8'd255};
    logic [BW-1:0] wants[2]  = '{8'h04, 8'hfc};
    for (int t = 0; t < 2; t++) begin
      step(1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, BW'($urandom));
      step(1'b1, 1'b1, primes[t]);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, BW'($urandom));
      step(1'b1, 1'b1, finals[t]);
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== wants[t]) begin
        failures++;
        $display("FAIL wrap_%0d: got valid=%b data=%h, expected valid=1 data=%h",
                 t, valid_o, data_o, wants[t]);
      end
    end
  endtask

  task automatic test_gapped();
    int n = 0;
    step(1'b0, 1'b0, '0);
    while (n < 12) begin
      if ($urandom_range(0, 2) == 0) begin
        step(1'b1, 1'b0, BW'($urandom));
      end else begin
        n++;
        step(1'b1, 1'b1, BW'(n));
      end
      check_outputs("gapped");
    end
    tests_run++;
    if (data_o !== 8'd4) begin
      failures++;
      $display("FAIL gapped_final: got data=%h, expected 04", data_o);
    end
  endtask

  task automatic test_en_drop();
    step(1'b0, 1'b0, '0);
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, BW'(3 * i));
    step(1'b0, 1'b1, 8'h77);
    tests_run++;
    if (valid_o !== 1'b0 || data_o !== 8'd12) begin
      failures++;
      $display("FAIL en_drop_hold: got valid=%b data=%h, expected valid=0 data=0c",
               valid_o, data_o);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, BW'(100 + 2 * i));
      tests_run++;
      if (valid_o !== (i == 8) || (i == 8 && data_o !== 8'd8)) begin
        failures++;
        $display("FAIL en_drop_s%0d: got valid=%b data=%h, expected valid=%b data=08",
                 i, valid_o, data_o, (i == 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic prev = 1'b0;
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0), BW'($urandom));
      check_outputs("random");
      if (prev && valid_o) begin
        tests_run++;
        failures++;
        $display("FAIL back_to_back: got valid_o high two cycles running at %0d, expected 0", i);
      end
      prev = valid_o;
    end
  endtask

`ifdef CIC_COMB_OVF_FLAG_EN
  task automatic test_ovf();
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd20);
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'd10 || ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got valid=%b data=%h ovf=%b, expected 1/0a/1", valid_o, data_o, ovf_o);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd22);
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'd2 || ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got valid=%b data=%h ovf=%b, expected 1/02/1", valid_o, data_o, ovf_o);
    end
    step(1'b0, 1'b0, '0);
    tests_run++;
    if (ovf_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%b, expected 0", ovf_o);
    end
  endtask
`endif

  initial begin
    do_reset();
    test_reset();
    test_steady();
    test_wrap();
    test_gapped();
    test_en_drop();
    test_back_to_back();
`ifdef CIC_COMB_OVF_FLAG_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
